// File: rtl/sum_acc_pkg.sv
// sum_acc_pkg: shared state encoding, default sizes and count-width helper for sum_accumulator.
package sum_acc_pkg;
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;
  localparam int DEF_SUM_W = 5;
  localparam int DEF_ACC_W = 8;
  localparam int DEF_COUNT = 4;
  function automatic int cnt_w(int count);
    return $clog2(count + 1);
  endfunction
endpackage

// File: rtl/sum_acc_if.sv
// sum_acc_if: sample-in and window-result valid/ready handshakes of sum_accumulator.
interface sum_acc_if import sum_acc_pkg::*; #(
  parameter int SUM_W = DEF_SUM_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int COUNT = DEF_COUNT
);
  logic                     in_valid, in_ready, in_last;
  logic [SUM_W-1:0]         in_sum;
  logic                     out_valid, out_ready, out_ovf;
  logic [ACC_W-1:0]         out_total;
  logic [cnt_w(COUNT)-1:0]  out_count;
  modport master (output in_valid, in_sum, in_last, out_ready,
                  input  in_ready, out_valid, out_total, out_count, out_ovf);
  modport slave  (input  in_valid, in_sum, in_last, out_ready,
                  output in_ready, out_valid, out_total, out_count, out_ovf);
endinterface

// File: rtl/sum_acc_add.sv
// sum_acc_add: accumulator adder with carry detect; SUM_ACC_SAT_EN clamps to max on carry instead of wrapping.
module sum_acc_add #(
  parameter int SUM_W = 5,
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [SUM_W-1:0] i_sum,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_carry
);
  logic [ACC_W:0] w_full;
  assign w_full  = {1'b0, i_acc} + (ACC_W + 1)'(i_sum);
  assign o_carry = w_full[ACC_W];
`ifdef SUM_ACC_SAT_EN
  assign o_acc = o_carry ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
  assign o_acc = w_full[ACC_W-1:0];
`endif
endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates a window of COUNT samples (or up to in_last) and presents total/count/overflow.
// Optional saturation build: SUM_ACC_SAT_EN (see sum_acc_add).
module sum_accumulator import sum_acc_pkg::*; #(
  parameter int SUM_W = DEF_SUM_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int COUNT = DEF_COUNT
) (
  input  logic      clk,
  input  logic      rst_n,
  sum_acc_if.slave  bus
);
  localparam int CW = cnt_w(COUNT);
  state_t           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf, w_carry, w_accept, w_close, w_take;

  sum_acc_add #(.SUM_W(SUM_W), .ACC_W(ACC_W)) u_add (
    .i_acc   (r_acc),
    .i_sum   (bus.in_sum),
    .o_acc   (w_acc_nxt),
    .o_carry (w_carry)
  );

  always_comb begin
    w_accept    = bus.in_valid && r_state == ACCUM;
    w_close     = w_accept && (bus.in_last || r_cnt == CW'(COUNT - 1));
    w_take      = r_state == HOLD && bus.out_ready;
    w_state_nxt = w_close ? HOLD : w_take ? ACCUM : r_state;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + 1'b1;
        r_ovf <= r_ovf | w_carry;
      end else if (w_take) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end
    end

  assign bus.in_ready  = r_state == ACCUM;
  assign bus.out_valid = r_state == HOLD;
  assign bus.out_total = r_acc;
  assign bus.out_count = r_cnt;
  assign bus.out_ovf   = r_ovf;
endmodule
